// File: rtl/arr_pkg.sv
// Shared widths and types for the 2x2 weight-stationary systolic MAC tile.
package arr_pkg;

  localparam int unsigned DW    = 8;   // activation / weight width, unsigned
  localparam int unsigned ACC_W = 24;  // partial-sum / output width, unsigned

  typedef logic [DW-1:0]    act_t;
  typedef logic [ACC_W-1:0] psum_t;

endpackage : arr_pkg

// File: rtl/systolic_pe.sv
// One processing element of the weight-stationary array: a weight register
// (shifted in from above unless hold is set), an activation register that
// forwards the row's activation to the right-hand neighbour, and a psum
// register holding psum_in + a_in * w.
// Optional build macro: ARR_FAULT_INJECT_EN enables the err_mult / err_mac
// bit-0 inversion hooks on the product and the adder result.
module systolic_pe
  import arr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             err_mac,
  input  logic             err_mult,
  input  logic [DW-1:0]    w_in,
  input  logic [DW-1:0]    a_in,
  input  logic [ACC_W-1:0] psum_in,
  output logic [DW-1:0]    w_out,
  output logic [DW-1:0]    a_out,
  output logic [ACC_W-1:0] psum_out
);

  act_t  w_q;
  act_t  a_q;
  psum_t psum_q;
  psum_t prod;
  psum_t sum;

  // Multiply the incoming activation by the stationary weight and add the psum from above.
  always_comb begin
    prod = psum_t'({{DW{1'b0}}, a_in} * {{DW{1'b0}}, w_q});
`ifdef ARR_FAULT_INJECT_EN
    prod[0] = prod[0] ^ err_mult;
    sum     = psum_in + prod;
    sum[0]  = sum[0] ^ err_mac;
`else
    sum     = psum_in + prod;
`endif
  end

`ifndef ARR_FAULT_INJECT_EN
  // Fault controls stay on the port list but have no effect in this build.
  logic fault_unused;
  assign fault_unused = err_mac ^ err_mult;
`endif

  // Weight shift (gated by hold), activation forwarding and psum capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      a_q    <= '0;
      psum_q <= '0;
    end else begin
      if (!hold) begin
        w_q <= w_in;
      end
      a_q    <= a_in;
      psum_q <= sum;
    end
  end

  assign w_out    = w_q;
  assign a_out    = a_q;
  assign psum_out = psum_q;

endmodule : systolic_pe

// File: rtl/systolic_arr_2x2.sv
// 2x2 weight-stationary systolic MAC array (NPU compute core tile).
// Weights shift down column-wise until hold freezes them; activations enter
// at column 0 of each row (row 1 skewed one cycle later by the caller) and
// move right one PE per cycle; partial sums flow down and leave row 1.
// Optional build macro: ARR_FAULT_INJECT_EN makes Err_mult / Err_mac active;
// without it both ports are accepted and ignored.
module systolic_arr_2x2
  import arr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Err_mac,
  input  logic             Err_mult,
  input  logic [DW-1:0]    w1_in,
  input  logic [DW-1:0]    w2_in,
  input  logic [DW-1:0]    a1_in,
  input  logic [DW-1:0]    a2_in,
  output logic [ACC_W-1:0] c1_out,
  output logic [ACC_W-1:0] c2_out,
  input  logic             hold
);

  act_t  w_q  [2][2];
  act_t  a_q  [2][2];
  psum_t ps_q [2][2];

  for (genvar r = 0; r < 2; r++) begin : g_row
    for (genvar c = 0; c < 2; c++) begin : g_col
      act_t  w_src;
      act_t  a_src;
      psum_t p_src;

      if (r == 0) begin : g_top
        assign w_src = (c == 0) ? w1_in : w2_in;
        assign p_src = '0;
      end else begin : g_bot
        assign w_src = w_q[0][c];
        assign p_src = ps_q[0][c];
      end

      if (c == 0) begin : g_left
        assign a_src = (r == 0) ? a1_in : a2_in;
      end else begin : g_right
        assign a_src = a_q[r][0];
      end

      systolic_pe u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .err_mac  (Err_mac),
        .err_mult (Err_mult),
        .w_in     (w_src),
        .a_in     (a_src),
        .psum_in  (p_src),
        .w_out    (w_q[r][c]),
        .a_out    (a_q[r][c]),
        .psum_out (ps_q[r][c])
      );
    end
  end

  assign c1_out = ps_q[1][0];
  assign c2_out = ps_q[1][1];

endmodule : systolic_arr_2x2

// File: tb/tb_systolic_arr_2x2.sv
// Directed bench for systolic_arr_2x2. Stimulus pushes hand-computed
// expected column results (tagged with the clock edge after which they must
// appear) into per-column queues; a negedge monitor pops and compares.
module tb_systolic_arr_2x2;
  import arr_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             Err_mac;
  logic             Err_mult;
  logic             hold;
  logic [DW-1:0]    w1_in, w2_in, a1_in, a2_in;
  logic [ACC_W-1:0] c1_out, c2_out;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  typedef struct {
    int               cyc;
    logic [ACC_W-1:0] val;
    string            name;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  systolic_arr_2x2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Err_mac  (Err_mac),
    .Err_mult (Err_mult),
    .w1_in    (w1_in),
    .w2_in    (w2_in),
    .a1_in    (a1_in),
    .a2_in    (a2_in),
    .c1_out   (c1_out),
    .c2_out   (c2_out),
    .hold     (hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt++;

  // Scoreboard monitor: compare every queued expectation due at this edge.
  always @(negedge clk) begin
    exp_t e;
    while (q1.size() > 0 && q1[0].cyc <= ecnt) begin
      e = q1.pop_front();
      checks++;
      if (e.cyc < ecnt) begin
        failures++;
        $display("FAIL %s: c1 expectation for edge %0d was skipped (now edge %0d)", e.name, e.cyc, ecnt);
      end else if (c1_out !== e.val) begin
        failures++;
        $display("FAIL %s: c1_out=%0d expected=%0d (edge %0d)", e.name, c1_out, e.val, ecnt);
      end
    end
    while (q2.size() > 0 && q2[0].cyc <= ecnt) begin
      e = q2.pop_front();
      checks++;
      if (e.cyc < ecnt) begin
        failures++;
        $display("FAIL %s: c2 expectation for edge %0d was skipped (now edge %0d)", e.name, e.cyc, ecnt);
      end else if (c2_out !== e.val) begin
        failures++;
        $display("FAIL %s: c2_out=%0d expected=%0d (edge %0d)", e.name, c2_out, e.val, ecnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Two loads with hold=0, then freeze; the first pair ends up in row 1.
  task automatic load_w(input int w1a, input int w2a, input int w1b, input int w2b);
    hold  = 1'b0;
    w1_in = DW'(w1a);
    w2_in = DW'(w2a);
    tick();
    w1_in = DW'(w1b);
    w2_in = DW'(w2b);
    tick();
    hold = 1'b1;
  endtask

  // Stream two skewed activation pairs: a1 = x0,x1,0 and a2 = 0,y0,y1,0.
  task automatic stream(input string name, input int x0, input int x1, input int y0, input int y1,
                        input int c1a, input int c1b, input int c2a, input int c2b);
    int e;
    e = ecnt + 1;
    q1.push_back('{e + 1, ACC_W'(c1a), {name, "_c1_first"}});
    q1.push_back('{e + 2, ACC_W'(c1b), {name, "_c1_second"}});
    q2.push_back('{e + 2, ACC_W'(c2a), {name, "_c2_first"}});
    q2.push_back('{e + 3, ACC_W'(c2b), {name, "_c2_second"}});
    a1_in = DW'(x0); a2_in = '0;      tick();
    a1_in = DW'(x1); a2_in = DW'(y0); tick();
    a1_in = '0;      a2_in = DW'(y1); tick();
    a1_in = '0;      a2_in = '0;      tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; Err_mac = 1'b0; Err_mult = 1'b0; hold = 1'b0;
    w1_in = '0; w2_in = '0; a1_in = '0; a2_in = '0;

    // Reset state
    #12;
    chk("reset_c1", c1_out, '0);
    chk("reset_c2", c2_out, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic load and skewed stream
    load_w(1, 2, 3, 4);
    stream("basic", 1, 3, 2, 4, 5, 13, 8, 20);

    // hold keeps weights while the weight inputs change
    w1_in = 8'd9; w2_in = 8'd9;
    stream("hold", 1, 3, 2, 4, 5, 13, 8, 20);

    // Full-scale operands, no overflow at 24 bits
    load_w(255, 255, 255, 255);
    stream("max", 255, 0, 255, 0, 130050, 0, 130050, 0);

    // Fault injection
    load_w(1, 2, 3, 4);
    Err_mult = 1'b1;
`ifdef ARR_FAULT_INJECT_EN
    stream("err_mult", 1, 3, 2, 4, 5, 13, 10, 22);
`else
    stream("err_mult", 1, 3, 2, 4, 5, 13, 8, 20);
`endif
    Err_mac = 1'b1;
`ifdef ARR_FAULT_INJECT_EN
    stream("err_both", 1, 3, 2, 4, 7, 15, 8, 20);
`else
    stream("err_both", 1, 3, 2, 4, 5, 13, 8, 20);
`endif
    Err_mac = 1'b0; Err_mult = 1'b0;

    // Asynchronous reset mid-stream clears outputs and weights
    a1_in = 8'd5; a2_in = 8'd6;
    tick();
    tick();
    chk("pre_reset_c1_nonzero", ACC_W'(c1_out != '0), ACC_W'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_c1", c1_out, '0);
    chk("midrst_c2", c2_out, '0);
    a1_in = '0; a2_in = '0;
    tick();
    rst_n = 1'b1;
    hold  = 1'b1;
    stream("post_rst_no_w", 1, 3, 2, 4, 0, 0, 0, 0);
    load_w(1, 2, 3, 4);
    stream("reload", 1, 3, 2, 4, 5, 13, 8, 20);

    tick();
    tick();
    chk("q1_drained", ACC_W'(q1.size()), '0);
    chk("q2_drained", ACC_W'(q2.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_systolic_arr_2x2
